mem_region_router: RTL and testbench
====================================

# mem_region_router

Parametrised data-side memory router sitting between the CPU's load/store port and up to eight synchronous block-RAM regions (data segment, stack, MMIO scratch, ...). It decodes each accepted access against per-region address windows and computes a word index in ascending or descending (stack-style) order. It drives exactly one region, inserts per-region wait states, and returns registered read data with a ready pulse. It replaces the fixed two-window decode and combinational read mux with a handshaked, multi-cycle controller.

## Interface
Parameters:
- NUM_REGIONS, 2, number of regions (1..8)
- IDX_W, 14, word-index width driven to each region
- REGION_BASE, {32'h7FFF_0000, 32'h1001_0000}, packed NUM_REGIONS×32, lowest mapped byte address per region (region 0 in LSBs)
- REGION_LAST, {32'h7FFF_EFFC, 32'h1001_FFFC}, packed NUM_REGIONS×32, highest mapped word address, inclusive
- REGION_DESC, 2'b10, bit k=1: region k indexes downward from REGION_LAST
- REGION_WAIT, {4'd0, 4'd0}, packed NUM_REGIONS×4, extra wait cycles per region (0..15)

Ports:
- clk  in  1  CPU clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  store data
- rdata  out  32  load data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  unmapped-access flag, valid while ready=1
- mem_en  out  NUM_REGIONS  per-region enable, one-hot or zero
- mem_we  out  NUM_REGIONS  per-region write enable
- mem_addr  out  NUM_REGIONS×IDX_W  per-region word index
- mem_wdata  out  32  shared write data
- mem_rdata  in  NUM_REGIONS×32  per-region read data, one cycle after mem_en

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: on req=1, register we, addr, and wdata. Register the decoded region one-hot `hit` and index. Go to ACCESS.
- Decode: region k hits when REGION_BASE[k] ≤ addr ≤ REGION_LAST[k], compared unsigned over 32 bits. On overlapping windows the lowest k wins.
- Index, ascending: (addr − BASE[k]) >> 2. Descending: (LAST[k] − addr) >> 2. Both truncated to IDX_W bits.
- ACCESS: for exactly one cycle, mem_en[k]=1 and mem_we[k]=we_q. Load wait counter with REGION_WAIT[k]. Go to WAIT if the count is nonzero, else DONE.
- Unmapped access (hit=0): no mem_en. ACCESS goes straight to DONE, and the write is dropped.
- WAIT: counter decrements each cycle. Go to DONE when it reaches 1.
- DONE: ready=1 for one cycle. rdata = registered mem_rdata[k] for loads; 0 for stores and unmapped accesses. Return to IDLE.
- req is ignored outside IDLE. The CPU stalls on !ready.
- mem_addr and mem_wdata hold their last values between accesses. Only mem_en and mem_we qualify them.

## Timing
- Reset values: state=IDLE, ready=0, err=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0.
- Latency, req cycle to ready cycle: mapped access 2+REGION_WAIT[k] cycles; unmapped access 2 cycles.
- mem_rdata is captured in the cycle after ACCESS, or on the final WAIT cycle.
- rdata holds its value until the next DONE.
- Minimum spacing between accepted requests is 3+W cycles. A req asserted in the DONE cycle is not accepted until the IDLE cycle that follows.
- rst asserted in any state returns to IDLE at the next edge and clears mem_en and mem_we in that same cycle. No ready pulse is issued for an aborted access.

## Configuration
- MEM_ROUTER_ERR_EN defined: err=1 in DONE for an unmapped access, otherwise 0.
- MEM_ROUTER_ERR_EN undefined: err tied to 0 and the decode-miss logic for err is removed. Unmapped loads still return 0 and unmapped writes are still dropped.

## Test plan
- Load 0x1001_0008 from region 0 (ascending, wait 0) with RAM word 2 = 0xDEAD_BEEF -> mem_en=2'b01, mem_addr[0]=2, ready 2 cycles after req, rdata=0xDEAD_BEEF, err=0.
- Store 0x1234_5678 to 0x7FFF_EFF4 with region 1 descending and REGION_WAIT[1]=2 -> mem_en=2'b10, mem_we=2'b10, mem_addr[1]=2, ready 4 cycles after req, rdata=0.
- Load 0x0000_0100, unmapped, with MEM_ROUTER_ERR_EN defined -> mem_en never asserts, ready after 2 cycles, rdata=0, err=1. Without the macro: err=0.
- Boundaries: 0x1001_FFFC hits region 0 at index 0x3FFF. 0x1002_0000 misses. 0x7FFF_EFFC hits region 1 at index 0. 0x7FFF_F000 misses.
- Hold req high for 10 cycles -> exactly one access per 3+W cycles, one ready pulse each, no double mem_en.
- Assert rst during WAIT -> next cycle state=IDLE, ready=0, mem_en=0. No ready pulse follows, and a fresh load then completes normally.

Source files
------------

// File: rtl/mem_region_router.sv
// Data-side router: decodes CPU accesses onto up to eight BRAM windows with wait states.
// Define MEM_ROUTER_ERR_EN to report unmapped accesses on err.
module mem_region_router #(
   parameter int NUM_REGIONS = 2,
   parameter int IDX_W = 14,
   parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h7FFF_0000, 32'h1001_0000},
   parameter logic [NUM_REGIONS*32-1:0] REGION_LAST = {32'h7FFF_EFFC, 32'h1001_FFFC},
   parameter logic [NUM_REGIONS-1:0] REGION_DESC = 2'b10,
   parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd0, 4'd0}
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req,
   input  logic                         we,
   input  logic [31:0]                  addr,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata,
   output logic                         ready,
   output logic                         err,
   output logic [NUM_REGIONS-1:0]       mem_en,
   output logic [NUM_REGIONS-1:0]       mem_we,
   output logic [NUM_REGIONS*IDX_W-1:0] mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic [NUM_REGIONS*32-1:0]    mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t                 state;
   logic                   we_q;
   logic [NUM_REGIONS-1:0] hit_q;
   logic [3:0]             wait_q;
   logic [3:0]             cnt;
   logic [31:0]            rdata_q;

   logic [31:0]            wa;
   logic [31:0]            off;
   logic [NUM_REGIONS-1:0] dec_hit;
   logic [IDX_W-1:0]       dec_idx;
   logic [3:0]             dec_wait;
   logic [31:0]            rd_sel;

   assign wa = addr & 32'hFFFF_FFFC;

   // Scan from the top so the lowest matching region overrides the rest.
   always_comb begin
      dec_hit  = '0;
      dec_idx  = '0;
      dec_wait = '0;
      off      = '0;
      for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
         if (wa >= REGION_BASE[k*32 +: 32] && wa <= REGION_LAST[k*32 +: 32]) begin
            dec_hit    = '0;
            dec_hit[k] = 1'b1;
            off = REGION_DESC[k] ? REGION_LAST[k*32 +: 32] - wa
                                 : wa - REGION_BASE[k*32 +: 32];
            dec_idx  = IDX_W'(off >> 2);
            dec_wait = REGION_WAIT[k*4 +: 4];
         end
      end
   end

   always_comb begin
      rd_sel = '0;
      for (int k = 0; k < NUM_REGIONS; k++) begin
         if (hit_q[k] && !we_q)
            rd_sel = rd_sel | mem_rdata[k*32 +: 32];
      end
   end

   // The region's output register is live during DONE; rdata_q keeps it afterwards.
   assign rdata = (state == DONE) ? rd_sel : rdata_q;

`ifdef MEM_ROUTER_ERR_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         hit_q     <= '0;
         wait_q    <= '0;
         cnt       <= '0;
         rdata_q   <= '0;
         ready     <= 1'b0;
         mem_en    <= '0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef MEM_ROUTER_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         ready <= 1'b0;
`ifdef MEM_ROUTER_ERR_EN
         err_q <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (req) begin
                  we_q      <= we;
                  hit_q     <= dec_hit;
                  wait_q    <= dec_wait;
                  mem_en    <= dec_hit;
                  mem_we    <= we ? dec_hit : '0;
                  mem_wdata <= wdata;
                  for (int k = 0; k < NUM_REGIONS; k++) begin
                     if (dec_hit[k])
                        mem_addr[k*IDX_W +: IDX_W] <= dec_idx;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               mem_en <= '0;
               mem_we <= '0;
               cnt    <= wait_q;
               if (wait_q != 4'd0) begin
                  state <= WAIT;
               end else begin
                  state <= DONE;
                  ready <= 1'b1;
`ifdef MEM_ROUTER_ERR_EN
                  err_q <= ~|hit_q;
`endif
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
                  ready <= 1'b1;
`ifdef MEM_ROUTER_ERR_EN
                  err_q <= ~|hit_q;
`endif
               end
            end
            DONE: begin
               rdata_q <= rd_sel;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router with a two-region BRAM model.
// Region 1 uses two wait states; err expectations follow MEM_ROUTER_ERR_EN.
module tb_mem_region_router;

   localparam int IW = 14;
`ifdef MEM_ROUTER_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          ready;
   logic          err;
   logic [1:0]    mem_en;
   logic [1:0]    mem_we;
   logic [2*IW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   rd0 = '0;
   logic [31:0]   rd1 = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_region_router #(
      .NUM_REGIONS(2),
      .IDX_W(IW),
      .REGION_BASE({32'h7FFF_0000, 32'h1001_0000}),
      .REGION_LAST({32'h7FFF_EFFC, 32'h1001_FFFC}),
      .REGION_DESC(2'b10),
      .REGION_WAIT({4'd2, 4'd0})
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .we(we),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .ready(ready),
      .err(err),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata({rd1, rd0})
   );

   // Synchronous RAMs; unwritten words read as A000_<idx> / B000_<idx>.
   logic [31:0]    ram0 [0:16383];
   logic [31:0]    ram1 [0:16383];
   logic [16383:0] vld0 = '0;
   logic [16383:0] vld1 = '0;
   logic [IW-1:0]  ma0;
   logic [IW-1:0]  ma1;
   assign ma0 = mem_addr[IW-1:0];
   assign ma1 = mem_addr[2*IW-1:IW];

   always @(posedge clk) begin
      if (mem_en[0]) begin
         if (mem_we[0]) begin
            ram0[ma0] <= mem_wdata;
            vld0[ma0] <= 1'b1;
         end else begin
            rd0 <= vld0[ma0] ? ram0[ma0] : (32'hA000_0000 | 32'(ma0));
         end
      end
      if (mem_en[1]) begin
         if (mem_we[1]) begin
            ram1[ma1] <= mem_wdata;
            vld1[ma1] <= 1'b1;
         end else begin
            rd1 <= vld1[ma1] ? ram1[ma1] : (32'hB000_0000 | 32'(ma1));
         end
      end
   end

   // Issues one request and follows it to ready (or a 30-cycle bound).
   task automatic run_access(input logic w, input logic [31:0] a,
                             input logic [31:0] d, output int lat,
                             output int en_cnt, output logic [1:0] en_s,
                             output logic [1:0] we_s, output logic [31:0] rd,
                             output logic er);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      lat = -1; en_cnt = 0; en_s = '0; we_s = '0; rd = 32'hFFFF_FFFF; er = 1'bx;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (mem_en != 2'b00) begin
            en_cnt++;
            en_s = mem_en;
            we_s = mem_we;
         end
         if (ready) begin
            lat = c;
            rd = rdata;
            er = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
      total++; if (mem_en !== 2'b00) begin bad++; $display("FAIL reset_mem_en got=%b want=00", mem_en); end
      total++; if (mem_we !== 2'b00) begin bad++; $display("FAIL reset_mem_we got=%b want=00", mem_we); end
      total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_load_asc();
      int lat, n;
      logic [1:0] e, w;
      logic [31:0] rd;
      logic er;
      run_access(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, lat, n, e, w, rd, er);
      total++; if (lat !== 2) begin bad++; $display("FAIL st0_latency got=%0d want=2", lat); end
      total++; if (w !== 2'b01) begin bad++; $display("FAIL st0_mem_we got=%b want=01", w); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL st0_rdata got=%h want=0", rd); end
      run_access(1'b0, 32'h1001_0008, 32'h0, lat, n, e, w, rd, er);
      total++; if (lat !== 2) begin bad++; $display("FAIL ld0_latency got=%0d want=2", lat); end
      total++; if (e !== 2'b01 || n !== 1) begin bad++; $display("FAIL ld0_mem_en got=%b x%0d want=01 x1", e, n); end
      total++; if (w !== 2'b00) begin bad++; $display("FAIL ld0_mem_we got=%b want=00", w); end
      total++; if (mem_addr[IW-1:0] !== 14'd2) begin bad++; $display("FAIL ld0_index got=%h want=2", mem_addr[IW-1:0]); end
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld0_rdata got=%h want=deadbeef", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL ld0_err got=%b want=0", er); end
      repeat (3) @(negedge clk);
      total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rdata_hold got=%h want=deadbeef", rdata); end
   endtask

   task automatic test_store_desc();
      int lat, n;
      logic [1:0] e, w;
      logic [31:0] rd;
      logic er;
      run_access(1'b1, 32'h7FFF_EFF4, 32'h1234_5678, lat, n, e, w, rd, er);
      total++; if (lat !== 4) begin bad++; $display("FAIL st1_latency got=%0d want=4", lat); end
      total++; if (e !== 2'b10 || n !== 1) begin bad++; $display("FAIL st1_mem_en got=%b x%0d want=10 x1", e, n); end
      total++; if (w !== 2'b10) begin bad++; $display("FAIL st1_mem_we got=%b want=10", w); end
      total++; if (mem_addr[2*IW-1:IW] !== 14'd2) begin bad++; $display("FAIL st1_index got=%h want=2", mem_addr[2*IW-1:IW]); end
      total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL st1_wdata got=%h want=12345678", mem_wdata); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL st1_rdata got=%h want=0", rd); end
      run_access(1'b0, 32'h7FFF_EFF4, 32'h0, lat, n, e, w, rd, er);
      total++; if (lat !== 4) begin bad++; $display("FAIL ld1_latency got=%0d want=4", lat); end
      total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ld1_rdata got=%h want=12345678", rd); end
   endtask

   task automatic test_unmapped();
      int lat, n;
      logic [1:0] e, w;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 32'h0000_0100, 32'h0, lat, n, e, w, rd, er);
      total++; if (lat !== 2) begin bad++; $display("FAIL um_latency got=%0d want=2", lat); end
      total++; if (n !== 0) begin bad++; $display("FAIL um_mem_en got=%0d cycles want=0", n); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL um_rdata got=%h want=0", rd); end
      total++; if (er !== ERR_ON) begin bad++; $display("FAIL um_err got=%b want=%b", er, ERR_ON); end
      run_access(1'b1, 32'h0000_0100, 32'h5555_AAAA, lat, n, e, w, rd, er);
      total++; if (n !== 0 || lat !== 2) begin bad++; $display("FAIL um_store got=%0d en lat=%0d want=0 en lat=2", n, lat); end
   endtask

   task automatic test_boundaries();
      int lat, n;
      logic [1:0] e, w;
      logic [31:0] rd;
      logic er;
      run_access(1'b0, 32'h1001_FFFC, 32'h0, lat, n, e, w, rd, er);
      total++; if (e !== 2'b01 || mem_addr[IW-1:0] !== 14'h3FFF) begin bad++; $display("FAIL top0 got en=%b idx=%h want en=01 idx=3fff", e, mem_addr[IW-1:0]); end
      total++; if (rd !== 32'hA000_3FFF) begin bad++; $display("FAIL top0_rdata got=%h want=a0003fff", rd); end
      run_access(1'b0, 32'h1002_0000, 32'h0, lat, n, e, w, rd, er);
      total++; if (n !== 0 || er !== ERR_ON || rd !== 32'h0) begin bad++; $display("FAIL miss_above0 got en=%0d err=%b rd=%h want en=0 err=%b rd=0", n, er, rd, ERR_ON); end
      total++; if (mem_addr[IW-1:0] !== 14'h3FFF) begin bad++; $display("FAIL addr_hold got=%h want=3fff", mem_addr[IW-1:0]); end
      run_access(1'b0, 32'h1000_FFFC, 32'h0, lat, n, e, w, rd, er);
      total++; if (n !== 0) begin bad++; $display("FAIL miss_below0 got en=%0d want=0", n); end
      run_access(1'b0, 32'h7FFF_EFFC, 32'h0, lat, n, e, w, rd, er);
      total++; if (e !== 2'b10 || mem_addr[2*IW-1:IW] !== 14'h0 || lat !== 4) begin bad++; $display("FAIL top1 got en=%b idx=%h lat=%0d want en=10 idx=0 lat=4", e, mem_addr[2*IW-1:IW], lat); end
      total++; if (rd !== 32'hB000_0000) begin bad++; $display("FAIL top1_rdata got=%h want=b0000000", rd); end
      run_access(1'b0, 32'h7FFF_F000, 32'h0, lat, n, e, w, rd, er);
      total++; if (n !== 0 || lat !== 2) begin bad++; $display("FAIL miss_above1 got en=%0d lat=%0d want en=0 lat=2", n, lat); end
      run_access(1'b0, 32'h7FFF_0002, 32'h0, lat, n, e, w, rd, er);
      total++; if (e !== 2'b10 || mem_addr[2*IW-1:IW] !== 14'h3BFF) begin bad++; $display("FAIL base1 got en=%b idx=%h want en=10 idx=3bff", e, mem_addr[2*IW-1:IW]); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rdy_seen;
      logic [15:0] en_seen;
      logic        dbl;
      logic [1:0]  prev;
      int          good_rd;
      rdy_seen = '0; en_seen = '0; dbl = 1'b0; prev = '0; good_rd = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h1001_0008;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         rdy_seen[i] = ready;
         en_seen[i] = (mem_en != 2'b00);
         if ((prev & mem_en) != 2'b00) dbl = 1'b1;
         prev = mem_en;
         if (ready && rdata === 32'hDEAD_BEEF) good_rd++;
         if (i == 10) req = 1'b0;
      end
      total++; if (rdy_seen !== 16'h0924) begin bad++; $display("FAIL b2b_ready got=%h want=0924", rdy_seen); end
      total++; if (en_seen !== 16'h0492) begin bad++; $display("FAIL b2b_mem_en got=%h want=0492", en_seen); end
      total++; if (dbl !== 1'b0) begin bad++; $display("FAIL b2b_double_en got=%b want=0", dbl); end
      total++; if (good_rd !== 4) begin bad++; $display("FAIL b2b_rdata got=%0d want=4", good_rd); end
   endtask

   task automatic test_reset_in_wait();
      int lat, n, late;
      logic [1:0] e, w;
      logic [31:0] rd;
      logic er;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h7FFF_EFF0;
      @(negedge clk);
      req = 1'b0;
      total++; if (mem_en !== 2'b10) begin bad++; $display("FAIL rw_access_en got=%b want=10", mem_en); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (ready !== 1'b0 || mem_en !== 2'b00 || mem_we !== 2'b00) begin bad++; $display("FAIL rw_abort got rdy=%b en=%b we=%b want 0 00 00", ready, mem_en, mem_we); end
      rst = 1'b0;
      late = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready) late++;
      end
      total++; if (late !== 0) begin bad++; $display("FAIL rw_no_ready got=%0d pulses want=0", late); end
      run_access(1'b0, 32'h1001_0008, 32'h0, lat, n, e, w, rd, er);
      total++; if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_fresh got lat=%0d rd=%h want lat=2 rd=deadbeef", lat, rd); end
   endtask

   initial begin
      test_reset();
      test_load_asc();
      test_store_desc();
      test_unmapped();
      test_boundaries();
      test_back_to_back();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
